// File: rtl/types_bus0_pkg.sv
// Shared bus0 segment types: master/slave totals and indices, the slave
// address map, arbiter state encoding and locally generated AXI responses.
package types_bus0_pkg;

  // Masters sharing the slave segment
  localparam int unsigned CFG_BUS0_XMST_CPU   = 0;
  localparam int unsigned CFG_BUS0_XMST_DMA   = 1;
  localparam int unsigned CFG_BUS0_XMST_TOTAL = 2;

  // Slaves on the segment
  localparam int unsigned CFG_BUS0_XSLV_BOOTROM = 0;
  localparam int unsigned CFG_BUS0_XSLV_CLINT   = 1;
  localparam int unsigned CFG_BUS0_XSLV_SRAM    = 2;
  localparam int unsigned CFG_BUS0_XSLV_PLIC    = 3;
  localparam int unsigned CFG_BUS0_XSLV_APB     = 4;
  localparam int unsigned CFG_BUS0_XSLV_DDR     = 5;
  localparam int unsigned CFG_BUS0_XSLV_PCIE    = 6;
  localparam int unsigned CFG_BUS0_XSLV_TOTAL   = 7;

  localparam int unsigned MAP_AW = 64;

  // Half-open window [addr_start, addr_end)
  typedef struct packed {
    logic [MAP_AW-1:0] addr_start;
    logic [MAP_AW-1:0] addr_end;
  } bus0_map_entry_t;

  localparam bus0_map_entry_t CFG_BUS0_MAP [CFG_BUS0_XSLV_TOTAL] = '{
    '{addr_start: 64'h0000_0000_0000_0000, addr_end: 64'h0000_0000_0001_0000},  // BOOTROM
    '{addr_start: 64'h0000_0000_0200_0000, addr_end: 64'h0000_0000_0201_0000},  // CLINT
    '{addr_start: 64'h0000_0000_0800_0000, addr_end: 64'h0000_0000_0810_0000},  // SRAM
    '{addr_start: 64'h0000_0000_0C00_0000, addr_end: 64'h0000_0000_1000_0000},  // PLIC
    '{addr_start: 64'h0000_0000_1000_0000, addr_end: 64'h0000_0000_1010_0000},  // APB
    '{addr_start: 64'h0000_0000_8000_0000, addr_end: 64'h0000_0000_C000_0000},  // DDR
    '{addr_start: 64'h0000_0001_0000_0000, addr_end: 64'h0000_0002_0000_0000}   // PCIE
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } bus0_arb_state_t;

  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/bus0_xslv_arbiter_if.sv
// Bus0 slave-segment arbiter interface.
// master modport: arbiter view (takes requests/slave handshakes, drives
// grants, slave address phase, response routing and local error beat).
// slave modport: environment view (masters + slaves around the arbiter).
interface bus0_xslv_arbiter_if
  import types_bus0_pkg::*;
#(
  parameter int unsigned ABITS = 48,
  parameter int unsigned NMST  = CFG_BUS0_XMST_TOTAL,
  parameter int unsigned NSLV  = CFG_BUS0_XSLV_TOTAL
);
  localparam int unsigned OW = (NMST > 1) ? $clog2(NMST) : 1;

  logic [NMST-1:0]       i_mst_req;
  logic [NMST*ABITS-1:0] i_mst_addr;
  logic [NMST-1:0]       o_mst_gnt;
  logic [OW-1:0]         o_owner;
  logic                  o_busy;
  logic                  o_slv_valid;
  logic [NSLV-1:0]       o_slv_sel;
  logic [ABITS-1:0]      o_slv_addr;
  logic                  i_slv_ready;
  logic                  i_resp_valid;
  logic                  i_resp_last;
  logic                  i_resp_ready;
  logic [NMST-1:0]       o_resp_route;
  logic                  o_err_valid;
  logic [1:0]            o_err_resp;
  logic                  o_slv_abort;

  modport master (
    input  i_mst_req, i_mst_addr, i_slv_ready, i_resp_valid, i_resp_last, i_resp_ready,
    output o_mst_gnt, o_owner, o_busy, o_slv_valid, o_slv_sel, o_slv_addr,
           o_resp_route, o_err_valid, o_err_resp, o_slv_abort
  );

  modport slave (
    output i_mst_req, i_mst_addr, i_slv_ready, i_resp_valid, i_resp_last, i_resp_ready,
    input  o_mst_gnt, o_owner, o_busy, o_slv_valid, o_slv_sel, o_slv_addr,
           o_resp_route, o_err_valid, o_err_resp, o_slv_abort
  );

endinterface

// File: rtl/bus0_addr_decoder.sv
// Combinational bus0 address decoder against CFG_BUS0_MAP.
// Ports: i_addr (address), o_sel (one-hot slave select), o_hit (mapped).
// Lowest slave index wins when windows overlap.
module bus0_addr_decoder
  import types_bus0_pkg::*;
#(
  parameter int unsigned ABITS = 48,
  parameter int unsigned NSLV  = CFG_BUS0_XSLV_TOTAL
) (
  input  logic [ABITS-1:0] i_addr,
  output logic [NSLV-1:0]  o_sel,
  output logic             o_hit
);

  // Scan high to low so the lowest matching index overwrites the rest
  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int s = int'(NSLV) - 1; s >= 0; s--) begin
      if ((i_addr >= ABITS'(CFG_BUS0_MAP[s].addr_start)) &&
          (i_addr <  ABITS'(CFG_BUS0_MAP[s].addr_end))) begin
        o_sel    = '0;
        o_sel[s] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus0_xslv_arbiter.sv
// Round-robin arbiter + address decoder for the bus0 slave segment.
// Ports: i_clk/i_rst (async active-high reset); bus (master modport):
//   per-master req/addr in, one-hot grant pulse out, owner/busy status,
//   slave address phase (valid/sel/addr, ready in), response beat
//   handshake in, owner routing, local DECERR/SLVERR beat, abort pulse.
// One transaction in flight; ownership held until the last response beat.
module bus0_xslv_arbiter
  import types_bus0_pkg::*;
#(
  parameter int unsigned ABITS   = 48,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned NMST    = CFG_BUS0_XMST_TOTAL,
  parameter int unsigned NSLV    = CFG_BUS0_XSLV_TOTAL
) (
  input logic i_clk,
  input logic i_rst,
  bus0_xslv_arbiter_if.master bus
);

  localparam int unsigned OW       = (NMST > 1) ? $clog2(NMST) : 1;
  localparam int unsigned CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = WDOG_EN ? CW'(TIMEOUT - 1) : '0;

  bus0_arb_state_t  state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [NSLV-1:0]  sel_q, sel_d;
  logic [1:0]       resp_q, resp_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [OW-1:0]    winner;
  logic             any_req;
  logic [ABITS-1:0] winner_addr;
  logic [NSLV-1:0]  dec_sel;
  logic             dec_hit;
  logic             hs_addr;
  logic             hs_resp;
  logic             abort;

  // Round-robin pick: first requester after the last winner
  always_comb begin
    logic found;
    found   = 1'b0;
    winner  = ptr_q;
    any_req = |bus.i_mst_req;
    for (int unsigned i = 1; i <= NMST; i++) begin
      if (!found && bus.i_mst_req[(32'(ptr_q) + i) % NMST]) begin
        winner = OW'((32'(ptr_q) + i) % NMST);
        found  = 1'b1;
      end
    end
  end

  assign winner_addr = bus.i_mst_addr[32'(winner) * ABITS +: ABITS];

  bus0_addr_decoder #(
    .ABITS (ABITS),
    .NSLV  (NSLV)
  ) u_dec (
    .i_addr (winner_addr),
    .o_sel  (dec_sel),
    .o_hit  (dec_hit)
  );

  assign hs_addr = (state_q == ADDR) && bus.i_slv_ready;
  assign hs_resp = (state_q == DATA) && bus.i_resp_valid && bus.i_resp_ready;

  // Watchdog fires only if no handshake rescues the final cycle
  assign abort = WDOG_EN && ((state_q == ADDR) || (state_q == DATA)) &&
                 (cnt_q == CNT_LAST) && !hs_addr && !hs_resp;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Transaction context registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q   <= OW'(NMST - 1);
      owner_q <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and context update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d   = winner;
          owner_d = winner;
          addr_d  = winner_addr;
          sel_d   = dec_sel;
          cnt_d   = '0;
          if (dec_hit) begin
            state_d = ADDR;
          end else begin
            state_d = ERR;
            resp_d  = AXI_RESP_DECERR;
          end
        end
      end
      ADDR: begin
        if (abort) begin
          state_d = ERR;
          resp_d  = AXI_RESP_SLVERR;
        end else if (hs_addr) begin
          state_d = DATA;
          cnt_d   = '0;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (abort) begin
          state_d = ERR;
          resp_d  = AXI_RESP_SLVERR;
        end else if (hs_resp) begin
          cnt_d = '0;
          if (bus.i_resp_last) state_d = IDLE;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERR: begin
        // Local error beat is single and implicitly last
        if (bus.i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; grant is gated by reset so nothing is offered while held
  always_comb begin
    bus.o_mst_gnt    = '0;
    bus.o_resp_route = '0;
    bus.o_busy       = (state_q != IDLE);
    bus.o_slv_valid  = (state_q == ADDR);
    bus.o_err_valid  = (state_q == ERR);
    bus.o_slv_abort  = abort;
    if ((state_q == IDLE) && any_req && !i_rst) bus.o_mst_gnt[winner] = 1'b1;
    if ((state_q == DATA) || (state_q == ERR))  bus.o_resp_route[owner_q] = 1'b1;
  end

  assign bus.o_owner    = owner_q;
  assign bus.o_slv_sel  = sel_q;
  assign bus.o_slv_addr = addr_q;
  assign bus.o_err_resp = resp_q;

endmodule
